// File: rtl/aud_pkg.sv
// aud_pkg: shared types for the audio playback scheduler.
// SLOW_INTERP_EN selects the interpolating slow-mode build.
package aud_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE
  } sched_state_t;

  typedef enum logic [2:0] {
    F_ADDR,
    F_WAIT,
    F_CAP,
    F_DIV,
    F_RDY
  } fetch_state_t;

  typedef logic signed [15:0] sample_t;

  localparam int MIN_FRAME_CYC = 34;

endpackage

// File: rtl/aud_interp_div.sv
// aud_interp_div: signed 20-bit by unsigned 4-bit restoring divider.
// One quotient bit per cycle; done pulses 21 cycles after start.
module aud_interp_div
  import aud_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [19:0] dividend,
  input  logic [3:0]         divisor,
  output logic signed [19:0] quotient,
  output logic               done
);

  logic [19:0] quo;
  logic [3:0]  rem;
  logic [3:0]  dvs;
  logic [4:0]  cnt;
  logic        neg;
  logic        busy;
  logic [4:0]  rem_sh;
  logic        ge;

  assign rem_sh = {rem, quo[19]};
  assign ge     = rem_sh >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      quo      <= '0;
      rem      <= '0;
      dvs      <= 4'd1;
      cnt      <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quo  <= dividend[19] ? -dividend : dividend;
        rem  <= '0;
        dvs  <= divisor;
        cnt  <= 5'd20;
        neg  <= dividend[19];
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt != 5'd0) begin
          quo <= {quo[18:0], ge};
          rem <= ge ? 4'(rem_sh - {1'b0, dvs}) : rem_sh[3:0];
          cnt <= cnt - 5'd1;
        end else begin
          // magnitude division then sign fix = truncation toward zero
          quotient <= neg ? -$signed(quo) : $signed(quo);
          done     <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/aud_play_sched.sv
// aud_play_sched: SRAM-to-I2S playback scheduler, one sample per DACLRCK frame.
// Define SLOW_INTERP_EN to build linear interpolation for slow playback.
module aud_play_sched
  import aud_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int SRAM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic [2:0]        i_speed,
  input  logic              i_interp,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrck,
  input  logic [15:0]       i_sram_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_dac_data,
  output logic              o_player_en,
  output logic              o_busy,
  output logic              o_done
);

  localparam int WCW = $clog2(MIN_FRAME_CYC);

  sched_state_t      state;
  fetch_state_t      fst;
  logic              lrck_d;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        k;
  logic [3:0]        n_q;
  logic              last_q;
  logic [WCW-1:0]    wcnt;
  sample_t           prep;

  logic              fall;
  logic [3:0]        n_new;
  logic              fast_new;
  logic              chg;
  logic [3:0]        adv;
  logic [2:0]        k_nxt;
  logic [ADDR_W:0]   sum;
  logic              over;
  logic              start_idle;
  logic              tick;
  logic              finish;
  logic              fetch_go;
  logic [ADDR_W-1:0] rd_addr;

  assign fall     = lrck_d & ~i_daclrck;
  assign n_new    = {1'b0, i_speed} + 4'd1;
  assign fast_new = i_fast & (i_speed != 3'd0);
  assign chg      = n_new != n_q;

  always_comb begin
    adv   = 4'd0;
    k_nxt = k;
    if (fast_new) begin
      adv   = n_new;
      k_nxt = 3'd0;
    end else if (chg) begin
      k_nxt = 3'd0;
    end else if (k == 3'(n_q - 4'd1)) begin
      adv   = 4'd1;
      k_nxt = 3'd0;
    end else begin
      k_nxt = k + 3'd1;
    end
  end

  // one extra bit so a step past the last address is seen, not wrapped
  assign sum  = {1'b0, addr} + {{(ADDR_W-3){1'b0}}, adv};
  assign over = sum > {1'b0, i_end_addr};

  assign start_idle = (state == S_IDLE) & i_start & ~i_pause & ~i_stop;
  assign tick   = (state == S_PLAY) & fall & ~i_stop & ~i_pause
                & (fst == F_RDY) & ~last_q;
  assign finish = (state == S_PLAY) & fall & ~i_stop & ~i_pause & last_q;
  assign fetch_go = start_idle | tick;

  assign o_player_en = state == S_PLAY;
  assign o_busy      = state != S_IDLE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      lrck_d     <= 1'b0;
      addr       <= '0;
      k          <= '0;
      n_q        <= 4'd1;
      last_q     <= 1'b0;
      o_dac_data <= '0;
      o_done     <= 1'b0;
    end else begin
      lrck_d <= i_daclrck;
      o_done <= 1'b0;
      if (i_stop) begin
        state      <= S_IDLE;
        addr       <= '0;
        k          <= '0;
        last_q     <= 1'b0;
        o_dac_data <= '0;
      end else if (finish) begin
        state  <= S_IDLE;
        last_q <= 1'b0;
        o_done <= 1'b1;
      end else if (tick) begin
        o_dac_data <= prep;
        n_q        <= n_new;
        if ((adv != 4'd0) && over) begin
          last_q <= 1'b1;
        end else begin
          addr <= sum[ADDR_W-1:0];
          k    <= k_nxt;
        end
      end else if (start_idle) begin
        state  <= S_PLAY;
        addr   <= '0;
        k      <= '0;
        n_q    <= n_new;
        last_q <= 1'b0;
      end else if ((state == S_PLAY) && i_pause) begin
        state <= S_PAUSE;
      end else if ((state == S_PAUSE) && i_start) begin
        state <= S_PLAY;
      end
    end
  end

`ifdef SLOW_INTERP_EN
  logic               interp_q;
  logic               second;
  sample_t            s0;
  logic               need_s1;
  logic               div_start;
  logic               div_done;
  logic signed [16:0] diff;
  logic signed [19:0] diff20;
  logic signed [19:0] k20;
  logic signed [19:0] prod;
  logic signed [19:0] q;
  logic [3:0]         unused_qhi;

  assign need_s1 = interp_q & (addr != i_end_addr) & (k != 3'd0);
  assign rd_addr = second ? addr + {{(ADDR_W-1){1'b0}}, 1'b1} : addr;
  assign diff    = $signed({i_sram_data[15], i_sram_data})
                 - $signed({s0[15], s0});
  assign diff20  = {{3{diff[16]}}, diff};
  assign k20     = {17'd0, k};
  assign prod    = diff20 * k20;
  assign div_start  = (fst == F_CAP) & second & ~i_stop;
  assign unused_qhi = q[19:16];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      interp_q <= 1'b0;
    end else if (fetch_go) begin
      interp_q <= i_interp;
    end
  end

  aud_interp_div u_div (
    .clk      (i_clk),
    .rst      (i_rst | i_stop),
    .start    (div_start),
    .dividend (prod),
    .divisor  (n_q),
    .quotient (q),
    .done     (div_done)
  );
`else
  logic unused_interp;

  assign rd_addr       = addr;
  assign unused_interp = i_interp;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst || i_stop) begin
      fst         <= F_RDY;
      o_sram_addr <= '0;
      wcnt        <= '0;
      prep        <= '0;
`ifdef SLOW_INTERP_EN
      second      <= 1'b0;
      s0          <= '0;
`endif
    end else if (fetch_go) begin
      fst <= F_ADDR;
`ifdef SLOW_INTERP_EN
      second <= 1'b0;
`endif
    end else begin
      unique case (fst)
        F_ADDR: begin
          o_sram_addr <= rd_addr;
          wcnt        <= '0;
          fst         <= F_WAIT;
        end
        F_WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WCW'(SRAM_LAT - 1)) fst <= F_CAP;
        end
`ifdef SLOW_INTERP_EN
        F_CAP: begin
          if (second) begin
            fst <= F_DIV;
          end else if (need_s1) begin
            s0     <= i_sram_data;
            second <= 1'b1;
            fst    <= F_ADDR;
          end else begin
            s0   <= i_sram_data;
            prep <= i_sram_data;
            fst  <= F_RDY;
          end
        end
        F_DIV: begin
          if (div_done) begin
            prep <= s0 + q[15:0];
            fst  <= F_RDY;
          end
        end
`else
        F_CAP: begin
          prep <= i_sram_data;
          fst  <= F_RDY;
        end
        F_DIV: fst <= F_RDY;
`endif
        F_RDY: fst <= F_RDY;
        default: fst <= F_RDY;
      endcase
    end
  end

endmodule
